// File: rtl/test_signal_gen_if.sv
// -----------------------------------------------------------------------------
// test_signal_gen_if
// Command channel of the test signal generator: a valid/ready handshake that
// carries a 2-bit command type and a CounterWidth-bit operand.
//   CmdValid  master -> slave   command present
//   CmdReady  slave  -> master  command can be accepted this cycle
//   CmdType   master -> slave   00 set half-period, 01 advance, 10 retard,
//                               11 enable/disable (CmdValue[0] selects)
//   CmdValue  master -> slave   command operand
// -----------------------------------------------------------------------------
interface test_signal_gen_if #(
    parameter int CounterWidth = 8
);
    logic                    CmdValid;
    logic                    CmdReady;
    logic [1:0]              CmdType;
    logic [CounterWidth-1:0] CmdValue;

    modport master (
        output CmdValid,
        output CmdType,
        output CmdValue,
        input  CmdReady
    );

    modport slave (
        input  CmdValid,
        input  CmdType,
        input  CmdValue,
        output CmdReady
    );
endinterface

// File: rtl/test_signal_gen.sv
// -----------------------------------------------------------------------------
// test_signal_gen
// Programmable square-wave source used to stimulate a DPLL. The half-period can
// be reprogrammed (taking effect on the next toggle), and the phase of the
// current half can be nudged earlier or later once per half-period.
// Ports:
//   MainClock   sole clock, rising edge
//   Reset       synchronous, active-high
//   cmd         command handshake (see test_signal_gen_if)
//   SignalGen   generated square wave
//   Edge        one-cycle pulse in the cycle SignalGen takes its new value
//   HalfPeriod  half-period currently in force
//   Running     high while generating
// -----------------------------------------------------------------------------
module test_signal_gen #(
    parameter int CounterWidth      = 8,
    parameter int DefaultHalfPeriod = 20
) (
    input  logic                    MainClock,
    input  logic                    Reset,
    test_signal_gen_if.slave        cmd,
    output logic                    SignalGen,
    output logic                    Edge,
    output logic [CounterWidth-1:0] HalfPeriod,
    output logic                    Running
);
    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] CMD_SET = 2'b00;
    localparam logic [1:0] CMD_ADV = 2'b01;
    localparam logic [1:0] CMD_RET = 2'b10;

    localparam logic [CounterWidth-1:0] DEF_HP = CounterWidth'(DefaultHalfPeriod);
    localparam logic [CounterWidth-1:0] MIN_HP = CounterWidth'(2);
    localparam logic [CounterWidth-1:0] ONE    = CounterWidth'(1);
    localparam logic [CounterWidth-1:0] MAX_T  = {CounterWidth{1'b1}};

    logic [0:0]              state_q, state_d;
    logic [CounterWidth-1:0] counter_q, counter_d;
    logic [CounterWidth-1:0] terminal_q, terminal_d;
    logic [CounterWidth-1:0] half_q, half_d;
    logic [CounterWidth-1:0] pend_val_q, pend_val_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    sig_q, sig_d;
    logic                    edge_q, edge_d;
    logic                    stall_q, stall_d;

    logic                    accept;
    logic                    is_run;
    logic                    is_adv;
    logic                    nat_toggle;
    logic                    force_toggle;
    logic                    toggle;
    logic [CounterWidth-1:0] set_val;
    logic [CounterWidth-1:0] adv_term;
    logic [CounterWidth-1:0] ret_term;
    logic [CounterWidth:0]   ret_sum;

    always_comb begin
        accept   = cmd.CmdValid && !stall_q;
        is_run   = (state_q == ST_RUN);
        set_val  = (cmd.CmdValue < MIN_HP) ? MIN_HP : cmd.CmdValue;
        // Advance floors the terminal at 1; retard saturates at all-ones.
        adv_term = (terminal_q <= cmd.CmdValue) ? ONE : (terminal_q - cmd.CmdValue);
        ret_sum  = {1'b0, terminal_q} + {1'b0, cmd.CmdValue};
        ret_term = ret_sum[CounterWidth] ? MAX_T : ret_sum[CounterWidth-1:0];

        is_adv       = accept && is_run && (cmd.CmdType == CMD_ADV);
        nat_toggle   = is_run && (counter_q == (terminal_q - ONE));
        // An advance that pulls the terminal at or behind the counter must
        // toggle straight away rather than wait for a wrap that never comes.
        force_toggle = is_adv && (counter_q >= (adv_term - ONE));
        toggle       = nat_toggle || force_toggle;

        state_d    = state_q;
        counter_d  = is_run ? (counter_q + ONE) : '0;
        terminal_d = terminal_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        sig_d      = sig_q;
        edge_d     = 1'b0;
        stall_d    = stall_q;

        // Toggle uses pre-command state; a pending half-period takes effect here.
        if (toggle) begin
            sig_d     = ~sig_q;
            edge_d    = 1'b1;
            counter_d = '0;
            stall_d   = 1'b0;
            if (pend_vld_q) begin
                half_d     = pend_val_q;
                terminal_d = pend_val_q;
                pend_vld_d = 1'b0;
            end else begin
                terminal_d = half_q;
            end
        end

        if (accept) begin
            case (cmd.CmdType)
                CMD_SET: begin
                    if (is_run) begin
                        // Applied after the toggle above, so a set arriving on
                        // a toggle cycle waits for the following toggle.
                        pend_val_d = set_val;
                        pend_vld_d = 1'b1;
                    end else begin
                        half_d     = set_val;
                        terminal_d = set_val;
                    end
                end
                CMD_ADV: begin
                    // When the half is already ending, the reload wins and the
                    // toggle itself ends the one-step-per-half window.
                    if (is_run && !toggle) begin
                        terminal_d = adv_term;
                        stall_d    = 1'b1;
                    end
                end
                CMD_RET: begin
                    if (is_run && !toggle) begin
                        terminal_d = ret_term;
                        stall_d    = 1'b1;
                    end
                end
                default: begin
                    if (cmd.CmdValue[0] && !is_run) begin
                        state_d    = ST_RUN;
                        counter_d  = '0;
                        sig_d      = 1'b0;
                        terminal_d = half_q;
                    end else if (!cmd.CmdValue[0] && is_run) begin
                        state_d   = ST_STOP;
                        counter_d = '0;
                        sig_d     = 1'b0;
                        edge_d    = 1'b0;
                        stall_d   = 1'b0;
                        if (pend_vld_q) begin
                            half_d     = pend_val_q;
                            terminal_d = pend_val_q;
                            pend_vld_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge MainClock) begin
        if (Reset) begin
            state_q    <= ST_STOP;
            counter_q  <= '0;
            terminal_q <= DEF_HP;
            half_q     <= DEF_HP;
            pend_val_q <= '0;
            pend_vld_q <= 1'b0;
            sig_q      <= 1'b0;
            edge_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            terminal_q <= terminal_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            sig_q      <= sig_d;
            edge_q     <= edge_d;
            stall_q    <= stall_d;
        end
    end

    assign cmd.CmdReady = ~stall_q;
    assign SignalGen    = sig_q;
    assign Edge         = edge_q;
    assign HalfPeriod   = half_q;
    assign Running      = (state_q == ST_RUN);
endmodule

// File: tb/tb_test_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_test_signal_gen
// Drives the generator through directed scenarios and a long random command
// stream. A reference model tracks, per half-period, its total length and the
// edges left before the toggle; every cycle the DUT outputs are compared with
// it. Directed scenarios also pin half lengths to hand-computed values.
// -----------------------------------------------------------------------------
module tb_test_signal_gen;
    localparam int CW     = 8;
    localparam int DEF_HP = 20;
    localparam int MAX_T  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sig_gen;
    logic          edge_o;
    logic          running;
    logic [CW-1:0] half_period;

    test_signal_gen_if #(.CounterWidth(CW)) cmd_bus ();

    test_signal_gen #(
        .CounterWidth(CW),
        .DefaultHalfPeriod(DEF_HP)
    ) dut (
        .MainClock (clk),
        .Reset     (rst),
        .cmd       (cmd_bus),
        .SignalGen (sig_gen),
        .Edge      (edge_o),
        .HalfPeriod(half_period),
        .Running   (running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge_cyc = 0;
    int last_gap      = 0;
    bit model_ok      = 1'b0;

    // Reference model: observable outputs plus the current half's length and
    // the number of clock edges remaining until it ends.
    bit m_run, m_sig, m_edge, m_stall;
    int m_hp, m_pend, m_len, m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int t, input int val);
        bit acc, start, stop;
        int new_pend, nl, el;
        if (r) begin
            m_run = 0; m_sig = 0; m_edge = 0; m_stall = 0;
            m_hp = DEF_HP; m_pend = -1; m_len = DEF_HP; m_left = DEF_HP;
            return;
        end
        acc = v && !m_stall;
        start = 0; stop = 0; new_pend = -1;
        if (acc) begin
            case (t)
                0: begin
                    nl = (val < 2) ? 2 : val;
                    if (m_run) new_pend = nl;
                    else m_hp = nl;
                end
                1: if (m_run && m_left != 1) begin
                    el     = m_len - m_left;
                    nl     = (m_len - val < 1) ? 1 : m_len - val;
                    m_len  = nl;
                    m_left = (nl - el < 1) ? 1 : nl - el;
                    m_stall = 1;
                end
                2: if (m_run && m_left != 1) begin
                    nl     = (m_len + val > MAX_T) ? MAX_T : m_len + val;
                    m_left = m_left + (nl - m_len);
                    m_len  = nl;
                    m_stall = 1;
                end
                default: begin
                    if ((val & 1) == 1 && !m_run) start = 1;
                    else if ((val & 1) == 0 && m_run) stop = 1;
                end
            endcase
        end
        m_edge = 0;
        if (stop) begin
            if (m_pend >= 0) begin m_hp = m_pend; m_pend = -1; end
            m_run = 0; m_sig = 0; m_stall = 0;
        end else if (start) begin
            m_run = 1; m_sig = 0; m_len = m_hp; m_left = m_hp;
        end else if (m_run) begin
            if (m_left == 1) begin
                m_sig = !m_sig; m_edge = 1; m_stall = 0;
                if (m_pend >= 0) begin m_hp = m_pend; m_pend = -1; end
                m_len = m_hp; m_left = m_hp;
            end else begin
                m_left--;
            end
        end
        if (new_pend >= 0) m_pend = new_pend;
    endtask

    // One clock cycle: compare outputs to the model, present inputs, advance.
    task automatic tick(input bit r, input bit v, input int t, input int val);
        @(negedge clk);
        if (model_ok) begin
            chk("SignalGen",  sig_gen,          m_sig);
            chk("Edge",       edge_o,           m_edge);
            chk("HalfPeriod", half_period,      m_hp);
            chk("Running",    running,          m_run);
            chk("CmdReady",   cmd_bus.CmdReady, !m_stall);
        end
        rst              = r;
        cmd_bus.CmdValid = v;
        cmd_bus.CmdType  = 2'(t);
        cmd_bus.CmdValue = CW'(val);
        @(posedge clk);
        model_step(r, v, t, val);
        if (r) model_ok = 1'b1;
        cyc++;
        #1;
        if (edge_o === 1'b1) begin
            last_gap      = cyc - last_edge_cyc;
            last_edge_cyc = cyc;
        end
        // A run's first half is timed from the cycle Running first reads 1.
        if (running !== 1'b1) last_edge_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
    endtask

    task automatic run_to_edge(input string name);
        int n;
        n = 0;
        do begin
            tick(0, 0, 0, 0);
            n++;
        end while (edge_o !== 1'b1 && n < 600);
        chk(name, edge_o, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_running"}, running,          0);
        chk({tag, "_sig"},     sig_gen,          0);
        chk({tag, "_edge"},    edge_o,           0);
        chk({tag, "_hp"},      half_period,      DEF_HP);
        chk({tag, "_ready"},   cmd_bus.CmdReady, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_bus.CmdValid = 1'b0;
        cmd_bus.CmdType  = 2'b00;
        cmd_bus.CmdValue = '0;

        tick(1, 0, 0, 0);
        check_reset_values("rst");

        // Enable: first rise 20 cycles after Running, then every 20.
        tick(0, 1, 3, 1);
        chk("en_running", running, 1);
        run_to_edge("first_rise");
        chk("first_rise_gap", last_gap, 20);
        chk("first_rise_sig", sig_gen, 1);
        run_to_edge("second_edge");
        chk("second_gap", last_gap, 20);
        chk("second_sig", sig_gen, 0);

        // Set 10 at counter 5: current half stays 20, later halves are 10.
        idle(5);
        tick(0, 1, 0, 10);
        chk("set_pending_hp", half_period, 20);
        run_to_edge("set_edge");
        chk("set_cur_half", last_gap, 20);
        chk("set_hp_at_toggle", half_period, 10);
        run_to_edge("set_next");
        chk("set_next_half", last_gap, 10);

        // Back to 20, then advance 5 at counter 3 with a stalled second advance.
        tick(0, 1, 0, 20);
        run_to_edge("restore_edge");
        chk("restore_hp", half_period, 20);
        idle(3);
        tick(0, 1, 1, 5);
        chk("adv_ready_low", cmd_bus.CmdReady, 0);
        tick(0, 1, 1, 5);
        chk("adv_stalled_ready", cmd_bus.CmdReady, 0);
        run_to_edge("adv_edge");
        chk("adv_half", last_gap, 15);
        chk("adv_ready_back", cmd_bus.CmdReady, 1);
        idle(12);
        tick(0, 1, 1, 30);
        chk("adv_big_edge", edge_o, 1);
        chk("adv_big_half", last_gap, 13);

        // Retard 250: this half 255, next half 20.
        tick(0, 1, 2, 250);
        run_to_edge("ret_edge");
        chk("ret_half", last_gap, 255);
        run_to_edge("ret_next");
        chk("ret_next_half", last_gap, 20);

        // Set 0 and set 1 both clamp to 2.
        tick(0, 1, 0, 0);
        run_to_edge("set0_edge");
        chk("set0_hp", half_period, 2);
        run_to_edge("set0_next");
        chk("set0_half", last_gap, 2);
        tick(0, 1, 0, 1);
        run_to_edge("set1_edge");
        chk("set1_hp", half_period, 2);
        run_to_edge("set1_next");
        chk("set1_half", last_gap, 2);

        // Disable mid-half while SignalGen is high.
        tick(0, 1, 0, 20);
        run_to_edge("pre_dis_edge");
        if (sig_gen !== 1'b1) run_to_edge("pre_dis_edge2");
        idle(5);
        tick(0, 1, 3, 0);
        chk("dis_running", running, 0);
        chk("dis_sig", sig_gen, 0);
        chk("dis_edge", edge_o, 0);
        chk("dis_hp", half_period, 20);

        // Reset mid-run with a pending set, a phase stall and a colliding command.
        tick(0, 1, 3, 1);
        run_to_edge("r32_edge");
        tick(0, 1, 0, 7);
        idle(2);
        tick(0, 1, 1, 2);
        chk("r32_stall", cmd_bus.CmdReady, 0);
        idle(4);
        tick(1, 1, 0, 5);
        check_reset_values("r32");
        tick(0, 1, 3, 1);
        run_to_edge("r32_rerun");
        chk("r32_first_half", last_gap, 20);
        run_to_edge("r32_rerun2");
        chk("r32_second_half", last_gap, 20);
        chk("r32_hp", half_period, 20);

        // Random command stream.
        for (int i = 0; i < 6000; i++) begin
            bit r, v;
            int t, val;
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 5) == 0);
            t = int'($urandom_range(0, 3));
            case (t)
                0:       val = int'($urandom_range(0, 40));
                1, 2:    val = ($urandom_range(0, 9) == 0) ? 250 : int'($urandom_range(0, 30));
                default: val = ($urandom_range(0, 7) == 0) ? 0 : 1;
            endcase
            tick(r, v, t, val);
        end
        tick(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/test_signal_gen.md
TEST_SIGNAL_GEN -- requirements
Module: test_signal_gen

Interface
REQ-001 Parameter CounterWidth, default 8: width of half-period counter, CmdValue and HalfPeriod.
REQ-002 Parameter DefaultHalfPeriod, default 20: half-period in MainClock cycles after reset.
REQ-003 MainClock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 CmdValid  input  1  command present.
REQ-006 CmdReady  output  1  command can be accepted this cycle.
REQ-007 CmdType  input  2  00 set half-period, 01 phase advance, 10 phase retard, 11 enable/disable.
REQ-008 CmdValue  input  CounterWidth  command operand.
REQ-009 SignalGen  output  1  generated square wave that drives the DPLL SignalIn.
REQ-010 Edge  output  1  one-cycle pulse coincident with each SignalGen toggle.
REQ-011 HalfPeriod  output  CounterWidth  half-period currently in force.
REQ-012 Running  output  1  high in RUN state.

Function
REQ-013 Two states, STOP and RUN. Type 11 with CmdValue[0]=1 moves STOP->RUN. Type 11 with CmdValue[0]=0 moves RUN->STOP.
REQ-014 A command is accepted on a cycle with CmdValid=1 and CmdReady=1. Its effect is visible from the following cycle; same-cycle toggle logic uses pre-command values.
REQ-015 In RUN, the counter increments every cycle. When counter == Terminal-1: next edge toggles SignalGen, asserts Edge for exactly that cycle, zeroes counter, and reloads Terminal from HalfPeriod. SignalGen period = 2*HalfPeriod cycles.
REQ-016 RUN entry: counter=0, SignalGen=0, Terminal=HalfPeriod; first toggle lands HalfPeriod cycles after the cycle Running first reads 1.
REQ-017 Set half-period (00): value held pending and copied to HalfPeriod and Terminal at the next toggle. In STOP it is copied immediately. CmdValue < 2 is clamped to 2. A later set overwrites an earlier pending one.
REQ-018 Phase advance (01), RUN only: Terminal = max(Terminal - CmdValue, 1) for the current half only. If counter >= new Terminal-1, toggle on the next cycle.
REQ-019 Phase retard (10), RUN only: Terminal = min(Terminal + CmdValue, 2^CounterWidth - 1) for the current half only, saturating with no wrap.
REQ-020 Phase commands in STOP are accepted and discarded.
REQ-021 After a phase command is accepted, CmdReady = 0 until the next toggle edge, limiting phase steps to one per half-period. CmdReady is otherwise 1.
REQ-022 Disable (RUN->STOP): next cycle SignalGen=0, Edge=0, counter=0, and any pending set is applied to HalfPeriod.
REQ-023 Enable while RUN and disable while STOP are accepted and have no effect.
REQ-024 Edge is never asserted in STOP. SignalGen holds between toggles.

Reset
REQ-025 Reset=1 at a rising edge sets, on the next cycle: STOP, SignalGen=0, Edge=0, Running=0, CmdReady=1, HalfPeriod=DefaultHalfPeriod, counter=0, pending cleared. This holds from any state and at any counter value.
REQ-026 Reset has priority over a simultaneously presented command; that command is not accepted.

Verification
REQ-027 Reset, then enable: SignalGen rises 20 cycles after Running=1 and then toggles every 20 cycles (period 40). Edge fires once per toggle.
REQ-028 RUN at HalfPeriod 20, set 10 at counter 5: current half still lasts 20 cycles, later halves last 10. HalfPeriod changes 20->10 on the toggle cycle.
REQ-029 Advance 5 at counter 3: that half lasts 15 cycles. CmdReady stays 0 until the toggle, and a second advance is stalled until then. Advance 30 at counter 12: toggle on the next cycle.
REQ-030 Retard 250 at HalfPeriod 20 (width 8): that half lasts 255 cycles, the following half lasts 20.
REQ-031 Set 0 and set 1: HalfPeriod = 2 and period = 4. Disable mid-half: SignalGen=0 next cycle with no Edge.
REQ-032 Reset asserted mid-run with a pending set and phase stall: all outputs take REQ-025 values next cycle, and the pending set is discarded.
